// File: rtl/pipe_stage_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_pkg
// Shared definitions for the CPU pipeline registers: the bus widths of the
// core, the default payload width of a pipe_stage, and the state encoding
// used by every pipe_stage instance.
// ---------------------------------------------------------------------------
package pipe_stage_pkg;

  // Core bus widths; stage payloads are concatenations of these.
  localparam int REG_BUS_W  = 32;
  localparam int INST_BUS_W = 32;

  // Default payload width of a pipe_stage.
  localparam int PIPE_DW_DEFAULT = 32;

  // Stage occupancy states: nothing held, main register only, main + skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_t;

  // Number of entries held in a given state.
  function automatic logic [1:0] state_occ(input pipe_state_t s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      ST_BUSY: n = 2'd1;
      ST_FULL: n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// ---------------------------------------------------------------------------
// pipe_stage
// Valid/ready pipeline register with optional two-entry skid buffer, stall
// and flush. Used for every inter-stage register of the CPU.
//
// Parameters
//   DW      payload width in bits
//   SKID    1: main + skid register, in_ready depends only on state
//           0: main register only, in_ready passes through when draining
//   RST_VAL payload value loaded into both registers on reset
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake, in_data payload
//   out_valid/out_ready downstream handshake, out_data payload (main reg)
//   stall               blocks the output transfer even if out_ready is high
//   flush               drops every held and incoming payload
//   occ                 number of entries held (0..2)
// ---------------------------------------------------------------------------
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int            DW      = PIPE_DW_DEFAULT,
  parameter int            SKID    = 1,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  input  logic          stall,
  input  logic          flush,
  output logic [1:0]    occ
);

  pipe_state_t   state;
  logic [DW-1:0] main_q;
  logic [DW-1:0] skid_q;
  logic          accept;
  logic          fire;

  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;
  assign occ       = state_occ(state);

  assign fire   = out_valid && out_ready && !stall;
  assign accept = in_valid && in_ready;

  // With a skid entry the stage can always absorb one more payload unless
  // both registers are occupied, so in_ready never sees out_ready or stall.
  // Without it, a held payload must leave in the same cycle to make room.
  assign in_ready = (SKID != 0) ? (state != ST_FULL)
                                : ((state == ST_EMPTY) || fire);

  // Occupancy FSM and payload registers. Flush only clears validity; the
  // payload registers keep their contents so flush never touches the datapath.
  // In FULL the skid entry moves into main when the head leaves, which keeps
  // FIFO order. The BUSY->FULL branch is unreachable when SKID is 0 because
  // in_ready then requires a fire whenever the stage is BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_EMPTY;
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state  <= ST_BUSY;
            main_q <= in_data;
          end
        end
        ST_BUSY: begin
          if (accept && fire) begin
            main_q <= in_data;
          end else if (accept && (SKID != 0)) begin
            state  <= ST_FULL;
            skid_q <= in_data;
          end else if (fire) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (fire) begin
            state  <= ST_BUSY;
            main_q <= skid_q;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage
// Directed test of pipe_stage with one skid-buffer instance (SKID=1) and one
// single-register instance (SKID=0), both 8 bits wide with RST_VAL 0x5A.
// ---------------------------------------------------------------------------
module tb_pipe_stage;

  localparam logic [7:0] RV = 8'h5A;

  logic       clk;
  logic       rst;

  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_stall, s_flush;
  logic [7:0] s_in_data, s_out_data;
  logic [1:0] s_occ;

  logic       r_in_valid, r_in_ready, r_out_valid, r_out_ready, r_stall, r_flush;
  logic [7:0] r_in_data, r_out_data;
  logic [1:0] r_occ;

  int checkCount;
  int passCount;

  pipe_stage #(.DW(8), .SKID(1), .RST_VAL(RV)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s_in_valid),
    .in_ready (s_in_ready),
    .in_data  (s_in_data),
    .out_valid(s_out_valid),
    .out_ready(s_out_ready),
    .out_data (s_out_data),
    .stall    (s_stall),
    .flush    (s_flush),
    .occ      (s_occ)
  );

  pipe_stage #(.DW(8), .SKID(0), .RST_VAL(RV)) u_reg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (r_in_valid),
    .in_ready (r_in_ready),
    .in_data  (r_in_data),
    .out_valid(r_out_valid),
    .out_ready(r_out_ready),
    .out_data (r_out_data),
    .stall    (r_stall),
    .flush    (r_flush),
    .occ      (r_occ)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count it.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, actual, expected, $time);
    end
  endtask

  // Drive the inputs of one instance (sel 1 = skid, 0 = single register).
  task automatic applyStimulus(input bit sel, input logic vld,
                               input logic [7:0] data, input logic ordy,
                               input logic stl, input logic fls);
    if (sel) begin
      s_in_valid = vld; s_in_data = data; s_out_ready = ordy;
      s_stall = stl; s_flush = fls;
    end else begin
      r_in_valid = vld; r_in_data = data; r_out_ready = ordy;
      r_stall = stl; r_flush = fls;
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the bench always ends.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset state.
    #2;
    checkOutput("rst_out_valid", {31'd0, s_out_valid}, 32'd0);
    checkOutput("rst_occ",       {30'd0, s_occ},       32'd0);
    checkOutput("rst_in_ready",  {31'd0, s_in_ready},  32'd1);
    checkOutput("rst_out_data",  {24'd0, s_out_data},  32'h5A);
    checkOutput("rst_r_in_ready",{31'd0, r_in_ready},  32'd1);
    #10;
    rst = 1'b0;

    // Streaming with out_ready high: one-cycle latency, occ stays 1.
    applyStimulus(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("stream_d0",   {24'd0, s_out_data}, 32'h11);
    checkOutput("stream_occ0", {30'd0, s_occ},      32'd1);
    applyStimulus(1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("stream_d1",   {24'd0, s_out_data}, 32'h22);
    checkOutput("stream_rdy1", {31'd0, s_in_ready}, 32'd1);
    applyStimulus(1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("stream_d2",   {24'd0, s_out_data}, 32'h33);
    checkOutput("stream_occ2", {30'd0, s_occ},      32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("stream_drain", {30'd0, s_occ}, 32'd0);

    // Backpressure: fill to FULL, A2 waits upstream, then drain in order.
    applyStimulus(1'b1, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("bp_occ1", {30'd0, s_occ}, 32'd1);
    applyStimulus(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("bp_occ2",   {30'd0, s_occ},      32'd2);
    checkOutput("bp_nrdy",   {31'd0, s_in_ready}, 32'd0);
    applyStimulus(1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("bp_hold",   {24'd0, s_out_data}, 32'hA0);
    checkOutput("bp_occ2b",  {30'd0, s_occ},      32'd2);
    applyStimulus(1'b1, 1'b1, 8'hA2, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("bp_rdy_reg", {31'd0, s_in_ready}, 32'd0);
    tick();
    checkOutput("bp_out1",   {24'd0, s_out_data}, 32'hA1);
    checkOutput("bp_occ1b",  {30'd0, s_occ},      32'd1);
    tick();
    checkOutput("bp_out2",   {24'd0, s_out_data}, 32'hA2);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("bp_empty",  {31'd0, s_out_valid}, 32'd0);

    // Flush from FULL with an incoming payload offered.
    applyStimulus(1'b1, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("fl_full", {30'd0, s_occ}, 32'd2);
    applyStimulus(1'b1, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("fl_occ",   {30'd0, s_occ},       32'd0);
    checkOutput("fl_valid", {31'd0, s_out_valid}, 32'd0);
    checkOutput("fl_keep",  {24'd0, s_out_data},  32'hB0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("fl_nob2", {31'd0, s_out_valid}, 32'd0);

    // Flush while BUSY with an accept in the same cycle: accept is dropped.
    applyStimulus(1'b1, 1'b1, 8'hB3, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 8'hB4, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("fl_rdy", {31'd0, s_in_ready}, 32'd1);
    tick();
    checkOutput("fl_busy_occ", {30'd0, s_occ},      32'd0);
    checkOutput("fl_busy_dat", {24'd0, s_out_data}, 32'hB3);

    // Stall with out_ready high holds the head; release gives one fire.
    applyStimulus(1'b1, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("stall_dat%0d", i), {24'd0, s_out_data}, 32'hC0);
      checkOutput($sformatf("stall_occ%0d", i), {30'd0, s_occ},      32'd1);
    end
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("stall_fire", {30'd0, s_occ}, 32'd0);

    // Asynchronous reset mid-cycle while FULL.
    applyStimulus(1'b1, 1'b1, 8'hD0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 8'hD1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("ar_full", {30'd0, s_occ}, 32'd2);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_valid", {31'd0, s_out_valid}, 32'd0);
    checkOutput("ar_occ",   {30'd0, s_occ},       32'd0);
    checkOutput("ar_data",  {24'd0, s_out_data},  32'h5A);
    tick();
    #2;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'hE0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("ar_first", {24'd0, s_out_data}, 32'hE0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Single-register instance: in_ready only opens when the head leaves.
    applyStimulus(1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("r_d5", {24'd0, r_out_data}, 32'h05);
    applyStimulus(1'b0, 1'b1, 8'h06, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("r_nrdy", {31'd0, r_in_ready}, 32'd0);
    tick();
    checkOutput("r_hold", {24'd0, r_out_data}, 32'h05);
    checkOutput("r_occ1", {30'd0, r_occ},      32'd1);
    applyStimulus(1'b0, 1'b1, 8'h06, 1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("r_stall_nrdy", {31'd0, r_in_ready}, 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h06, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("r_pass_rdy", {31'd0, r_in_ready}, 32'd1);
    tick();
    checkOutput("r_d6",   {24'd0, r_out_data}, 32'h06);
    checkOutput("r_occ6", {30'd0, r_occ},      32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("r_empty", {31'd0, r_out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
